// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters (CPU control unit, debug/loader)
// and the memory-controller arbiter. The arbiter uses the slave modport; the
// requesters (or a bench driving them) use the master modport.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_load;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_gnt;
  logic        dbg_req;
  logic        dbg_load;
  logic        dbg_rd;
  logic        dbg_wr;
  logic        dbg_gnt;
  logic        mem_load;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] stall_cnt;

  modport slave (
    input  cpu_req, cpu_load, cpu_rd, cpu_wr,
    input  dbg_req, dbg_load, dbg_rd, dbg_wr,
    output cpu_gnt, dbg_gnt,
    output mem_load, mem_rd, mem_wr,
    output owner, busy, stall_cnt
  );

  modport master (
    output cpu_req, cpu_load, cpu_rd, cpu_wr,
    output dbg_req, dbg_load, dbg_rd, dbg_wr,
    input  cpu_gnt, dbg_gnt,
    input  mem_load, mem_rd, mem_wr,
    input  owner, busy, stall_cnt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory controller strobes between the CPU control
// unit and the debug/loader master. One owner at a time, round-robin on
// contention, bounded hold time (MAX_HOLD, 0 disables preemption) and
// TURN_CYCLES dead cycles between owners.
// Optional feature macro: ARB_STATS_EN builds the saturating stall counter;
// without it stall_cnt is tied to zero.
module mem_bus_arbiter #(
  parameter int unsigned MAX_HOLD    = 16,
  parameter int unsigned TURN_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2,
    TURN    = 2'd3
  } state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam bit         TURN_EN    = (TURN_CYCLES != 0);
  localparam logic [7:0] HOLD_LAST  = PREEMPT_EN ? 8'(MAX_HOLD - 1) : 8'd0;
  localparam logic [3:0] TURN_LAST  = TURN_EN ? 4'(TURN_CYCLES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;
  logic       last_dbg_q, last_dbg_d;
  logic       cpu_gnt_q, dbg_gnt_q, busy_q;
  logic [1:0] owner_q;
  logic       cpu_leave, dbg_leave;

  // Round-robin pick: on contention the master that did not own the bus last wins.
  function automatic state_t arbitrate(input logic cpu_req, input logic dbg_req,
                                       input logic last_dbg);
    if (cpu_req && dbg_req) return last_dbg ? GNT_CPU : GNT_DBG;
    else if (cpu_req)       return GNT_CPU;
    else if (dbg_req)       return GNT_DBG;
    else                    return IDLE;
  endfunction

  // Owner gives up the bus on release or when its contended hold budget is spent.
  assign cpu_leave = !bus.cpu_req ||
                     (PREEMPT_EN && bus.dbg_req && (hold_q == HOLD_LAST));
  assign dbg_leave = !bus.dbg_req ||
                     (PREEMPT_EN && bus.cpu_req && (hold_q == HOLD_LAST));

  // Next-state, hold/turnaround counters and round-robin history.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    last_dbg_d = last_dbg_q;
    case (state_q)
      IDLE: state_d = arbitrate(bus.cpu_req, bus.dbg_req, last_dbg_q);
      GNT_CPU: begin
        if (cpu_leave) begin
          last_dbg_d = 1'b0;
          state_d    = TURN_EN ? TURN : arbitrate(bus.cpu_req, bus.dbg_req, 1'b0);
        end else if (bus.dbg_req && (hold_q != 8'hFF)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      GNT_DBG: begin
        if (dbg_leave) begin
          last_dbg_d = 1'b1;
          state_d    = TURN_EN ? TURN : arbitrate(bus.cpu_req, bus.dbg_req, 1'b1);
        end else if (bus.cpu_req && (hold_q != 8'hFF)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) state_d = arbitrate(bus.cpu_req, bus.dbg_req, last_dbg_q);
        else                     turn_d  = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Fresh grant starts a fresh hold budget; fresh turnaround starts counting at 0.
    if ((state_d != state_q) && ((state_d == GNT_CPU) || (state_d == GNT_DBG))) hold_d = 8'd0;
    if ((state_d == TURN) && (state_q != TURN)) turn_d = 4'd0;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= 8'd0;
      turn_q     <= 4'd0;
      last_dbg_q <= 1'b1;
      cpu_gnt_q  <= 1'b0;
      dbg_gnt_q  <= 1'b0;
      owner_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      last_dbg_q <= last_dbg_d;
      cpu_gnt_q  <= (state_d == GNT_CPU);
      dbg_gnt_q  <= (state_d == GNT_DBG);
      owner_q    <= {state_d == GNT_DBG, state_d == GNT_CPU};
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.cpu_gnt  = cpu_gnt_q;
  assign bus.dbg_gnt  = dbg_gnt_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;

  // Only the current owner's strobes reach the controller; the others are dropped.
  assign bus.mem_load = (cpu_gnt_q & bus.cpu_load) | (dbg_gnt_q & bus.dbg_load);
  assign bus.mem_rd   = (cpu_gnt_q & bus.cpu_rd)   | (dbg_gnt_q & bus.dbg_rd);
  assign bus.mem_wr   = (cpu_gnt_q & bus.cpu_wr)   | (dbg_gnt_q & bus.dbg_wr);

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic        stall_now;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One count per cycle in which any requester is kept waiting.
  assign stall_now = (bus.cpu_req & ~cpu_gnt_q) | (bus.dbg_req & ~dbg_gnt_q);

  // Saturating contention counter.
  always_ff @(posedge clk) begin
    if (rst)            stall_cnt_q <= 16'h0000;
    else if (stall_now) stall_cnt_q <= sat_inc16(stall_cnt_q);
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MAX_HOLD=4, TURN_CYCLES=1).
module tb_mem_bus_arbiter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    bus.cpu_load = 0; bus.cpu_rd = 0; bus.cpu_wr = 0;
    bus.dbg_load = 0; bus.dbg_rd = 0; bus.dbg_wr = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    bus.cpu_req = 0; bus.dbg_req = 0;
    clr_strobes();

    // 1: reset with both requesting and strobes active
    bus.cpu_req = 1; bus.dbg_req = 1;
    bus.cpu_rd = 1; bus.dbg_wr = 1;
    tick(); tick();
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rst_owner",   bus.owner, 2'b00);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_mem_rd",  bus.mem_rd, 0);
    chk("rst_mem_wr",  bus.mem_wr, 0);
    chk("rst_stall",   bus.stall_cnt, 0);
    clr_strobes();
    rst = 0;
    tick();
    chk("rel_cpu_first", bus.cpu_gnt, 1);
    chk("rel_dbg_gnt",   bus.dbg_gnt, 0);
    chk("rel_owner",     bus.owner, 2'b01);
    bus.cpu_req = 0; bus.dbg_req = 0;
    tick(); tick();
    chk("t1_idle_busy", bus.busy, 0);

    // 2: single CPU transaction, strobe pass-through, release timing
    bus.cpu_req = 1;
    tick();
    chk("t2_cpu_gnt", bus.cpu_gnt, 1);
    chk("t2_busy",    bus.busy, 1);
    bus.cpu_rd = 1; #1;
    chk("t2_mem_rd",  bus.mem_rd, 1);
    tick(); tick();
    chk("t2_still_gnt", bus.cpu_gnt, 1);
    bus.cpu_req = 0; bus.cpu_rd = 0;
    tick();
    chk("t2_turn_gnt",   bus.cpu_gnt, 0);
    chk("t2_turn_busy",  bus.busy, 1);
    chk("t2_turn_owner", bus.owner, 2'b00);
    tick();
    chk("t2_idle_busy",  bus.busy, 0);

    // mid-operation reset drops the grant at once, no turnaround
    bus.cpu_req = 1;
    tick();
    chk("mr_gnt_before", bus.cpu_gnt, 1);
    rst = 1;
    tick();
    chk("mr_cpu_gnt", bus.cpu_gnt, 0);
    chk("mr_busy",    bus.busy, 0);
    chk("mr_owner",   bus.owner, 2'b00);
    bus.cpu_req = 0;
    tick();
    rst = 0;

    // 3: both request, last owner DBG after reset -> CPU first, then DBG
    bus.cpu_req = 1; bus.dbg_req = 1;
    tick();
    chk("t3_cpu_gnt", bus.cpu_gnt, 1);
    chk("t3_dbg_wait", bus.dbg_gnt, 0);
    bus.cpu_req = 0;
    tick();
    chk("t3_turn_owner", bus.owner, 2'b00);
    chk("t3_turn_gnts",  {bus.cpu_gnt, bus.dbg_gnt}, 2'b00);
    tick();
    chk("t3_dbg_gnt",   bus.dbg_gnt, 1);
    chk("t3_dbg_owner", bus.owner, 2'b10);
    bus.dbg_req = 0;
    tick(); tick();
    chk("t3_idle", bus.busy, 0);

    // 4: preemption after 4 contended cycles, CPU regains after DBG
    bus.cpu_req = 1; bus.dbg_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_hold%0d", i), bus.cpu_gnt, 1);
    end
    tick();
    chk("t4_preempt_gnt",   bus.cpu_gnt, 0);
    chk("t4_preempt_owner", bus.owner, 2'b00);
    chk("t4_preempt_busy",  bus.busy, 1);
    tick();
    chk("t4_dbg_gnt", bus.dbg_gnt, 1);
    chk("t4_cpu_off", bus.cpu_gnt, 0);
`ifndef ARB_STATS_EN
    chk("t4_stall_off", bus.stall_cnt, 0);
`endif
    bus.dbg_req = 0;
    tick();
    chk("t4_turn2", bus.owner, 2'b00);
    tick();
    chk("t4_cpu_regain", bus.cpu_gnt, 1);
    bus.cpu_req = 0;
    tick(); tick();

    // 5: non-owner strobes ignored, owner strobes pass incl. final grant cycle
    bus.cpu_req = 1;
    tick();
    bus.dbg_wr = 1; bus.dbg_rd = 1; bus.dbg_load = 1; #1;
    chk("t5_dbg_wr_blk",   bus.mem_wr, 0);
    chk("t5_dbg_rd_blk",   bus.mem_rd, 0);
    chk("t5_dbg_load_blk", bus.mem_load, 0);
    bus.dbg_wr = 0; bus.dbg_rd = 0; bus.dbg_load = 0;
    bus.cpu_wr = 1; bus.cpu_load = 1; #1;
    chk("t5_cpu_wr",   bus.mem_wr, 1);
    chk("t5_cpu_load", bus.mem_load, 1);
    bus.cpu_req = 0; #1;
    chk("t5_last_cycle_wr", bus.mem_wr, 1);
    tick();
    chk("t5_turn_wr", bus.mem_wr, 0);
    tick();
    clr_strobes();
`ifndef ARB_STATS_EN
    chk("t5_stall_off", bus.stall_cnt, 0);
`endif

`ifdef ARB_STATS_EN
    // 6: stall statistic and saturation
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("t6_stall_clr", bus.stall_cnt, 0);
    bus.cpu_req = 1; bus.dbg_req = 1;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_turn", bus.owner, 2'b00);
    bus.cpu_req = 0;
    tick();
    chk("t6_dbg_gnt", bus.dbg_gnt, 1);
    chk("t6_stall6",  bus.stall_cnt, 6);
    bus.dbg_req = 0;
    tick(); tick();
    chk("t6_stall_hold", bus.stall_cnt, 6);
    bus.cpu_req = 1;
    tick();
    chk("t6_stall7", bus.stall_cnt, 7);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    bus.dbg_req = 1;
    tick();
    chk("t6_stall_max", bus.stall_cnt, 16'hFFFF);
    tick();
    chk("t6_stall_sat", bus.stall_cnt, 16'hFFFF);
    bus.cpu_req = 0; bus.dbg_req = 0;
    tick(); tick();
`else
    bus.cpu_req = 1; bus.dbg_req = 1;
    tick(); tick(); tick();
    chk("t6_stall_off", bus.stall_cnt, 0);
    bus.cpu_req = 0; bus.dbg_req = 0;
    tick(); tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
